// File: rtl/inst_fetcher.sv
// ----------------------------------------------------------------------------
// inst_fetcher
//   Instruction fetch stage with a direct-mapped, one-word-per-line icache.
//   Hits deliver one instruction per cycle; a miss issues a single request to
//   the memory controller and presents the returned word when it arrives.
//   A jump redirects the fetch pc at any time; a request already in flight is
//   still used to fill the cache, but its word is dropped.
//
// Ports
//   clk                 : clock, all state changes on its rising edge
//   rst                 : asynchronous active-high reset
//   rdy                 : global enable; low freezes every register
//   start_query_signal  : one-cycle fetch request to memory (out)
//   pc_to_mem           : fetch address of the outstanding request (out)
//   finish_query_signal : one-cycle completion pulse from memory (in)
//   inst_from_mem       : returned word, valid with finish_query_signal (in)
//   inst_valid_to_dec   : instruction available to the decoder (out)
//   inst_to_dec         : instruction word (out)
//   pc_to_dec           : address of inst_to_dec (out)
//   dec_ready           : decoder takes the presented word at this edge (in)
//   jump_flag           : one-cycle redirect pulse (in)
//   jump_target         : redirect address, valid with jump_flag (in)
// ----------------------------------------------------------------------------
module inst_fetcher #(
    parameter int ICACHE_IDX_BITS = 8
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        rdy,
    output logic        start_query_signal,
    output logic [31:0] pc_to_mem,
    input  logic        finish_query_signal,
    input  logic [31:0] inst_from_mem,
    output logic        inst_valid_to_dec,
    output logic [31:0] inst_to_dec,
    output logic [31:0] pc_to_dec,
    input  logic        dec_ready,
    input  logic        jump_flag,
    input  logic [31:0] jump_target
);

    localparam int LINES = 1 << ICACHE_IDX_BITS;
    localparam int TAG_W = 32 - ICACHE_IDX_BITS - 2;

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        WAIT_MEM = 2'd1,
        DISCARD  = 2'd2
    } state_t;

    state_t      state_reg, state_next;
    logic [31:0] pc_reg, pc_next;
    logic [31:0] mem_pc_reg, mem_pc_next;
    logic        start_reg, start_next;
    logic        inst_valid_reg, inst_valid_next;
    logic [31:0] inst_reg, inst_next;
    logic [31:0] pc_dec_reg, pc_dec_next;

    // Cache storage: valid bits need reset, tag/data do not.
    logic [LINES-1:0]     line_valid_reg;
    logic [TAG_W-1:0]     tag_mem  [LINES];
    logic [31:0]          data_mem [LINES];

    logic [ICACHE_IDX_BITS-1:0] lookup_idx;
    logic [TAG_W-1:0]           lookup_tag;
    logic                       hit;
    logic                       slot_free;

    // The fill always targets the address of the request in flight, which
    // may differ from pc_reg after a jump.
    logic                       fill_en;
    logic [ICACHE_IDX_BITS-1:0] fill_idx;
    logic [TAG_W-1:0]           fill_tag;

    assign lookup_idx = pc_reg[ICACHE_IDX_BITS+1:2];
    assign lookup_tag = pc_reg[31:ICACHE_IDX_BITS+2];
    assign hit        = line_valid_reg[lookup_idx] && (tag_mem[lookup_idx] == lookup_tag);
    assign slot_free  = !inst_valid_reg || dec_ready;

    assign fill_idx   = mem_pc_reg[ICACHE_IDX_BITS+1:2];
    assign fill_tag   = mem_pc_reg[31:ICACHE_IDX_BITS+2];

    // ------------------------------------------------------------------
    // Next-state / datapath control
    // ------------------------------------------------------------------
    always_comb begin
        state_next      = state_reg;
        pc_next         = pc_reg;
        mem_pc_next     = mem_pc_reg;
        start_next      = start_reg;
        inst_valid_next = inst_valid_reg;
        inst_next       = inst_reg;
        pc_dec_next     = pc_dec_reg;
        fill_en         = 1'b0;

        if (rdy) begin
            // The request pulse lasts exactly one enabled cycle.
            start_next = 1'b0;

            case (state_reg)
                IDLE: begin
                    if (jump_flag) begin
                        pc_next         = jump_target;
                        inst_valid_next = 1'b0;
                    end else if (slot_free) begin
                        if (hit) begin
                            inst_valid_next = 1'b1;
                            inst_next       = data_mem[lookup_idx];
                            pc_dec_next     = pc_reg;
                            pc_next         = pc_reg + 32'd4;
                        end else begin
                            inst_valid_next = 1'b0;
                            start_next      = 1'b1;
                            mem_pc_next     = pc_reg;
                            state_next      = WAIT_MEM;
                        end
                    end
                end

                WAIT_MEM: begin
                    if (slot_free) begin
                        inst_valid_next = 1'b0;
                    end
                    if (finish_query_signal) begin
                        fill_en = 1'b1;
                    end
                    if (jump_flag) begin
                        pc_next         = jump_target;
                        inst_valid_next = 1'b0;
                        state_next      = finish_query_signal ? IDLE : DISCARD;
                    end else if (finish_query_signal) begin
                        inst_valid_next = 1'b1;
                        inst_next       = inst_from_mem;
                        pc_dec_next     = pc_reg;
                        pc_next         = pc_reg + 32'd4;
                        state_next      = IDLE;
                    end
                end

                DISCARD: begin
                    if (slot_free) begin
                        inst_valid_next = 1'b0;
                    end
                    if (jump_flag) begin
                        pc_next         = jump_target;
                        inst_valid_next = 1'b0;
                    end
                    if (finish_query_signal) begin
                        fill_en    = 1'b1;
                        state_next = IDLE;
                    end
                end

                default: begin
                    state_next = IDLE;
                end
            endcase
        end
    end

    // ------------------------------------------------------------------
    // State registers
    // ------------------------------------------------------------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_reg      <= IDLE;
            pc_reg         <= 32'd0;
            mem_pc_reg     <= 32'd0;
            start_reg      <= 1'b0;
            inst_valid_reg <= 1'b0;
            inst_reg       <= 32'd0;
            pc_dec_reg     <= 32'd0;
        end else begin
            state_reg      <= state_next;
            pc_reg         <= pc_next;
            mem_pc_reg     <= mem_pc_next;
            start_reg      <= start_next;
            inst_valid_reg <= inst_valid_next;
            inst_reg       <= inst_next;
            pc_dec_reg     <= pc_dec_next;
        end
    end

    // Per-line valid bits; lines are only ever set, never invalidated.
    for (genvar gi = 0; gi < LINES; gi++) begin : g_line_valid
        always_ff @(posedge clk or posedge rst) begin
            if (rst) begin
                line_valid_reg[gi] <= 1'b0;
            end else if (fill_en && (fill_idx == ICACHE_IDX_BITS'(gi))) begin
                line_valid_reg[gi] <= 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (fill_en) begin
            tag_mem[fill_idx]  <= fill_tag;
            data_mem[fill_idx] <= inst_from_mem;
        end
    end

    // A pending pulse is masked while the pipeline is frozen and reappears
    // once rdy returns, so memory sees it exactly once.
    assign start_query_signal = start_reg && rdy;
    assign pc_to_mem          = mem_pc_reg;
    assign inst_valid_to_dec  = inst_valid_reg;
    assign inst_to_dec        = inst_reg;
    assign pc_to_dec          = pc_dec_reg;

endmodule

// File: tb/tb_inst_fetcher.sv
// ----------------------------------------------------------------------------
// tb_inst_fetcher
//   Directed scenarios followed by randomized traffic. The reference model
//   is an in-order instruction stream: it knows which pc the decoder must see
//   next, which word lives at each address, and which addresses have been
//   filled into the cache. The bench also plays the memory controller.
// ----------------------------------------------------------------------------
module tb_inst_fetcher;

    localparam int IDX = 8;

    logic        clk = 1'b0;
    logic        rst;
    logic        rdy;
    logic        start_query_signal;
    logic [31:0] pc_to_mem;
    logic        finish_query_signal;
    logic [31:0] inst_from_mem;
    logic        inst_valid_to_dec;
    logic [31:0] inst_to_dec;
    logic [31:0] pc_to_dec;
    logic        dec_ready;
    logic        jump_flag;
    logic [31:0] jump_target;

    always #5 clk = ~clk;

    inst_fetcher #(.ICACHE_IDX_BITS(IDX)) dut (
        .clk                 (clk),
        .rst                 (rst),
        .rdy                 (rdy),
        .start_query_signal  (start_query_signal),
        .pc_to_mem           (pc_to_mem),
        .finish_query_signal (finish_query_signal),
        .inst_from_mem       (inst_from_mem),
        .inst_valid_to_dec   (inst_valid_to_dec),
        .inst_to_dec         (inst_to_dec),
        .pc_to_dec           (pc_to_dec),
        .dec_ready           (dec_ready),
        .jump_flag           (jump_flag),
        .jump_target         (jump_target)
    );

    int n_checks = 0;
    int n_errors = 0;

    // Reference model state
    logic [31:0] pres_pc;          // pc of the next word the decoder must see
    logic [29:0] line_of [int];    // cache index -> word address held there
    bit          pending;          // memory request in flight
    logic [31:0] req_addr;
    int          cnt;
    int          delay_cfg;
    int          accepted;

    // Observations of the last cycle
    logic        obs_start, obs_valid;
    logic [31:0] obs_pc_mem, obs_pc_dec, obs_inst;

    function automatic logic [31:0] memfn(input logic [31:0] a);
        logic [31:0] w;
        w = {a[31:2], 2'b00};
        if (w == 32'd0) return 32'h0000_0013;
        return (w * 32'h9E37_79B1) ^ 32'h0F0F_5A5A;
    endfunction

    function automatic bit model_hit(input logic [31:0] a);
        int i;
        i = int'(a[IDX+1:2]);
        return line_of.exists(i) && (line_of[i] == a[31:2]);
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // One clock cycle: drive inputs at the falling edge, sample outputs,
    // check them against the model, advance the model as of the rising edge.
    task automatic cyc(input bit r, input bit dr, input bit j,
                       input logic [31:0] jt, input bit stray);
        bit fin;
        bit newreq;
        fin = pending && (cnt == 0);
        rdy                 = r;
        dec_ready           = dr;
        jump_flag           = j;
        jump_target         = jt;
        finish_query_signal = fin || stray;
        inst_from_mem       = fin ? memfn(req_addr) : 32'hDEAD_BEEF;
        #1;
        obs_start  = start_query_signal;
        obs_valid  = inst_valid_to_dec;
        obs_pc_mem = pc_to_mem;
        obs_pc_dec = pc_to_dec;
        obs_inst   = inst_to_dec;
        if (obs_valid) begin
            check("dec_pc", obs_pc_dec, pres_pc);
            check("dec_inst", obs_inst, memfn(pres_pc));
        end
        if (!r) check("start_gated_by_rdy", obs_start, 1'b0);
        newreq = 1'b0;
        if (obs_start) begin
            check("one_outstanding", pending, 1'b0);
            check("req_addr", obs_pc_mem, pres_pc);
            check("req_only_on_miss", model_hit(obs_pc_mem), 1'b0);
            newreq = 1'b1;
        end
        if (r) begin
            if (fin) begin
                line_of[int'(req_addr[IDX+1:2])] = req_addr[31:2];
                pending = 1'b0;
            end else if (pending && cnt > 0) begin
                cnt--;
            end
            if (j) begin
                pres_pc = jt;
            end else if (obs_valid && dr) begin
                pres_pc = pres_pc + 32'd4;
                accepted++;
            end
            if (newreq) begin
                pending  = 1'b1;
                req_addr = obs_pc_mem;
                cnt      = delay_cfg - 1;
            end
        end
        @(negedge clk);
    endtask

    // Asynchronous reset between clock edges; outputs must clear at once.
    task automatic do_reset();
        #2 rst = 1'b1;
        #1;
        check("rst_start", start_query_signal, 1'b0);
        check("rst_pc_mem", pc_to_mem, 32'd0);
        check("rst_valid", inst_valid_to_dec, 1'b0);
        check("rst_inst", inst_to_dec, 32'd0);
        check("rst_pc_dec", pc_to_dec, 32'd0);
        @(negedge clk);
        line_of.delete();
        pres_pc = 32'd0;
        pending = 1'b0;
        cnt     = 0;
        rst     = 1'b0;
    endtask

    task automatic wait_dec(input logic [31:0] a);
        int k;
        k = 0;
        while (!(inst_valid_to_dec && pc_to_dec == a) && k < 80) begin
            cyc(1'b1, 1'b1, 1'b0, 32'd0, 1'b0);
            k++;
        end
        check("wait_dec_valid", inst_valid_to_dec, 1'b1);
        check("wait_dec_pc", pc_to_dec, a);
    endtask

    task automatic wait_req(input logic [31:0] a);
        int k;
        bit saw_valid;
        k = 0;
        saw_valid = 1'b0;
        obs_start = 1'b0;
        while (!obs_start && k < 80) begin
            cyc(1'b1, 1'b1, 1'b0, 32'd0, 1'b0);
            saw_valid = saw_valid | obs_valid;
            k++;
        end
        check("wait_req_seen", obs_start, 1'b1);
        check("wait_req_addr", obs_pc_mem, a);
        check("wait_req_no_word", saw_valid, 1'b0);
    endtask

    logic [31:0] targets [8];

    initial begin
        targets = '{32'h0, 32'h4, 32'h400, 32'h404, 32'h20, 32'h102,
                    32'hFFFF_FFF8, 32'h100};
        rst = 1'b1; rdy = 1'b0; dec_ready = 1'b0; jump_flag = 1'b0;
        jump_target = 32'd0; finish_query_signal = 1'b0; inst_from_mem = 32'd0;
        pres_pc = 32'd0; pending = 1'b0; cnt = 0; delay_cfg = 5; accepted = 0;

        // Reset state
        repeat (2) @(negedge clk);
        #2;
        check("reset_valid", inst_valid_to_dec, 1'b0);
        check("reset_pc_mem", pc_to_mem, 32'd0);
        check("reset_start", start_query_signal, 1'b0);
        @(negedge clk);
        rst = 1'b0;

        // Cold miss, memory answers five cycles after the request
        cyc(1, 1, 0, 0, 0);
        check("cold_no_start_yet", obs_start, 1'b0);
        cyc(1, 1, 0, 0, 0);
        check("cold_start", obs_start, 1'b1);
        check("cold_pc_mem", obs_pc_mem, 32'd0);
        repeat (5) begin
            cyc(1, 1, 0, 0, 0);
            check("cold_wait_no_start", obs_start, 1'b0);
        end
        cyc(1, 1, 0, 0, 0);
        check("cold_valid", obs_valid, 1'b1);
        check("cold_inst", obs_inst, 32'h0000_0013);
        check("cold_pc_dec", obs_pc_dec, 32'd0);
        cyc(1, 1, 0, 0, 0);
        check("cold_next_start", obs_start, 1'b1);
        check("cold_next_pc_mem", obs_pc_mem, 32'd4);

        // Backpressure on the word at pc 8
        wait_dec(32'h8);
        repeat (3) begin
            cyc(1, 0, 0, 0, 0);
            check("bp_valid", obs_valid, 1'b1);
            check("bp_pc", obs_pc_dec, 32'h8);
            check("bp_inst", obs_inst, memfn(32'h8));
            check("bp_no_start", obs_start, 1'b0);
        end
        cyc(1, 1, 0, 0, 0);
        cyc(1, 1, 0, 0, 0);
        check("bp_release_start", obs_start, 1'b1);
        check("bp_release_pc_mem", obs_pc_mem, 32'hC);

        // Hit loop over the prefilled lines 0x0..0xC
        wait_dec(32'hC);
        cyc(1, 0, 1, 32'h0, 0);
        cyc(1, 1, 0, 0, 0);
        check("hit_jump_cleared", obs_valid, 1'b0);
        for (int k = 0; k < 4; k++) begin
            cyc(1, 1, 0, 0, 0);
            check("hit_valid", obs_valid, 1'b1);
            check("hit_pc", obs_pc_dec, 32'(4 * k));
            check("hit_no_start", obs_start, 1'b0);
        end

        // Jump while a miss for 0x20 is outstanding
        cyc(1, 1, 1, 32'h20, 0);
        wait_req(32'h20);
        cyc(1, 1, 1, 32'h100, 0);
        wait_req(32'h100);
        wait_dec(32'h100);
        cyc(1, 0, 1, 32'h20, 0);
        cyc(1, 0, 0, 0, 0);
        check("fill20_gap_valid", obs_valid, 1'b0);
        check("fill20_gap_start", obs_start, 1'b0);
        cyc(1, 0, 0, 0, 0);
        check("fill20_hit_valid", obs_valid, 1'b1);
        check("fill20_hit_pc", obs_pc_dec, 32'h20);
        check("fill20_hit_start", obs_start, 1'b0);

        // Freeze with rdy low mid-request, then jump coincident with finish
        cyc(1, 1, 0, 0, 0);
        wait_req(32'h24);
        repeat (4) begin
            cyc(0, 1, 1, 32'h80, 0);
            check("freeze_valid", obs_valid, 1'b0);
            check("freeze_pc_mem", obs_pc_mem, 32'h24);
        end
        begin
            int k;
            k = 0;
            while (!(pending && cnt == 0) && k < 20) begin
                cyc(1, 1, 0, 0, 0);
                k++;
            end
            check("coinc_finish_due", pending && cnt == 0, 1'b1);
        end
        cyc(1, 1, 1, 32'h40, 0);
        wait_req(32'h40);

        // Asynchronous reset while a word is presented
        wait_dec(32'h40);
        do_reset();
        cyc(1, 1, 0, 0, 0);
        cyc(1, 1, 0, 0, 0);
        check("rst1_req", obs_start, 1'b1);
        check("rst1_pc_mem", obs_pc_mem, 32'd0);
        // Asynchronous reset mid-request, stray completion afterwards
        do_reset();
        cyc(1, 1, 0, 0, 1);
        check("stray_valid", obs_valid, 1'b0);
        check("stray_start", obs_start, 1'b0);
        cyc(1, 1, 0, 0, 0);
        check("post_rst_req", obs_start, 1'b1);
        check("post_rst_pc_mem", obs_pc_mem, 32'd0);
        cyc(1, 1, 0, 0, 0);
        check("stray_ignored_valid", obs_valid, 1'b0);

        // Randomized traffic
        accepted = 0;
        for (int n = 0; n < 3000; n++) begin
            delay_cfg = int'($urandom_range(1, 6));
            cyc($urandom_range(0, 9) != 0,
                $urandom_range(0, 9) < 7,
                $urandom_range(0, 19) == 0,
                targets[$urandom_range(0, 7)],
                1'b0);
        end
        check("random_progress", accepted > 100, 1'b1);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
